// File: rtl/clint_mmio_pkg.sv
// Shared constants, decode types and helpers for the core-local interruptor.
// Base addresses and sizing defaults live here so mem_io and the CLINT agree.
package clint_mmio_pkg;

  localparam logic [31:0] CLINT_MSIP_BASE     = 32'h0200_0000;
  localparam logic [31:0] CLINT_MTIME_BASE    = 32'h0200_1000;
  localparam logic [31:0] CLINT_MTIMECMP_BASE = 32'h0200_2000;
  localparam int unsigned CLINT_NUM_HARTS     = 1;
  localparam int unsigned CLINT_TICK_DIV      = 1;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_MSIP,
    SEL_MTIME_LO,
    SEL_MTIME_HI,
    SEL_CMP_LO,
    SEL_CMP_HI
  } clint_sel_t;

  // Hart index is sized for the 32-hart maximum.
  typedef logic [4:0] hart_idx_t;

  typedef struct packed {
    clint_sel_t sel;
    hart_idx_t  hart;
    logic       err;
  } clint_dec_t;

  // Merge enabled bytes of new_val into old_val.
  function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_addr_dec.sv
// Combinational decode of a CLINT byte address into register select, hart
// index and access error (misaligned or unmapped).
module clint_addr_dec
  import clint_mmio_pkg::*;
#(
  parameter int unsigned NUM_HARTS     = CLINT_NUM_HARTS,
  parameter logic [31:0] MSIP_BASE     = CLINT_MSIP_BASE,
  parameter logic [31:0] MTIME_BASE    = CLINT_MTIME_BASE,
  parameter logic [31:0] MTIMECMP_BASE = CLINT_MTIMECMP_BASE
) (
  input  logic [31:0] addr_in,
  output clint_dec_t  dec_out
);

  localparam logic [31:0] MsipSpan = 32'(4 * NUM_HARTS);
  localparam logic [31:0] CmpSpan  = 32'(8 * NUM_HARTS);

  logic [31:0] msip_off;
  logic [31:0] cmp_off;

  // Offsets wrap for addresses below a base, so one unsigned compare covers the range.
  always_comb begin
    msip_off = addr_in - MSIP_BASE;
    cmp_off  = addr_in - MTIMECMP_BASE;
    dec_out  = '{sel: SEL_NONE, hart: '0, err: 1'b1};
    if (addr_in[1:0] == 2'b00) begin
      if (msip_off < MsipSpan) begin
        dec_out.sel  = SEL_MSIP;
        dec_out.hart = 5'(msip_off >> 2);
        dec_out.err  = 1'b0;
      end else if (addr_in == MTIME_BASE) begin
        dec_out.sel = SEL_MTIME_LO;
        dec_out.err = 1'b0;
      end else if (addr_in == MTIME_BASE + 32'd4) begin
        dec_out.sel = SEL_MTIME_HI;
        dec_out.err = 1'b0;
      end else if (cmp_off < CmpSpan) begin
        dec_out.sel  = cmp_off[2] ? SEL_CMP_HI : SEL_CMP_LO;
        dec_out.hart = 5'(cmp_off >> 3);
        dec_out.err  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/clint_mmio.sv
// Multi-hart CLINT: MSIP, MTIME and MTIMECMP behind a req/ack MMIO port,
// with a programmable mtime prescaler and registered timer compares.
module clint_mmio
  import clint_mmio_pkg::*;
#(
  parameter int unsigned NUM_HARTS     = CLINT_NUM_HARTS,
  parameter logic [31:0] MSIP_BASE     = CLINT_MSIP_BASE,
  parameter logic [31:0] MTIME_BASE    = CLINT_MTIME_BASE,
  parameter logic [31:0] MTIMECMP_BASE = CLINT_MTIMECMP_BASE,
  parameter int unsigned TICK_DIV      = CLINT_TICK_DIV
) (
  input  logic                 clk_in,
  input  logic                 reset_in,
  input  logic                 req_in,
  input  logic                 we_in,
  input  logic [31:0]          addr_in,
  input  logic [31:0]          wdata_in,
  input  logic [3:0]           be_in,
  output logic                 ack_out,
  output logic [31:0]          rdata_out,
  output logic                 err_out,
  output logic [NUM_HARTS-1:0] msip_out,
  output logic [NUM_HARTS-1:0] mtip_out,
  output logic [63:0]          mtime_out
);

  typedef enum logic [0:0] {StIdle, StResp} state_e;

  localparam logic [15:0] TickMax = 16'(TICK_DIV - 1);

  state_e               state_q, state_d;
  logic [15:0]          presc_q, presc_d;
  logic [63:0]          mtime_q, mtime_d;
  logic [63:0]          mtimecmp_q [NUM_HARTS];
  logic [63:0]          mtimecmp_d [NUM_HARTS];
  logic [NUM_HARTS-1:0] msip_q, msip_d;
  logic [NUM_HARTS-1:0] mtip_q, mtip_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 err_q, err_d;

  clint_dec_t  dec;
  logic        accept;
  logic        wr_ok;
  logic        tick;
  logic [31:0] rd_val;

  clint_addr_dec #(
    .NUM_HARTS     (NUM_HARTS),
    .MSIP_BASE     (MSIP_BASE),
    .MTIME_BASE    (MTIME_BASE),
    .MTIMECMP_BASE (MTIMECMP_BASE)
  ) u_addr_dec (
    .addr_in (addr_in),
    .dec_out (dec)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_in) begin
          accept  = 1'b1;
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign wr_ok = accept & we_in & ~dec.err;

  always_comb begin
    tick    = (presc_q == TickMax);
    presc_d = tick ? 16'd0 : presc_q + 16'd1;
  end

  // A write to either mtime half suppresses that cycle's increment entirely.
  always_comb begin
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    if (wr_ok && (be_in != 4'b0000)) begin
      if (dec.sel == SEL_MTIME_LO) begin
        mtime_d = {mtime_q[63:32], apply_be(mtime_q[31:0], wdata_in, be_in)};
      end else if (dec.sel == SEL_MTIME_HI) begin
        mtime_d = {apply_be(mtime_q[63:32], wdata_in, be_in), mtime_q[31:0]};
      end
    end
  end

  always_comb begin
    msip_d = msip_q;
    for (int h = 0; h < NUM_HARTS; h++) begin
      mtimecmp_d[h] = mtimecmp_q[h];
      mtip_d[h]     = (mtime_q >= mtimecmp_q[h]);
      if (wr_ok && (dec.hart == 5'(h))) begin
        if ((dec.sel == SEL_MSIP) && be_in[0]) msip_d[h] = wdata_in[0];
        if (dec.sel == SEL_CMP_LO) begin
          mtimecmp_d[h][31:0] = apply_be(mtimecmp_q[h][31:0], wdata_in, be_in);
        end
        if (dec.sel == SEL_CMP_HI) begin
          mtimecmp_d[h][63:32] = apply_be(mtimecmp_q[h][63:32], wdata_in, be_in);
        end
      end
    end
  end

  always_comb begin
    rd_val = '0;
    case (dec.sel)
      SEL_MSIP: begin
        for (int h = 0; h < NUM_HARTS; h++) begin
          if (dec.hart == 5'(h)) rd_val = {31'b0, msip_q[h]};
        end
      end
      SEL_MTIME_LO: rd_val = mtime_q[31:0];
      SEL_MTIME_HI: rd_val = mtime_q[63:32];
      SEL_CMP_LO: begin
        for (int h = 0; h < NUM_HARTS; h++) begin
          if (dec.hart == 5'(h)) rd_val = mtimecmp_q[h][31:0];
        end
      end
      SEL_CMP_HI: begin
        for (int h = 0; h < NUM_HARTS; h++) begin
          if (dec.hart == 5'(h)) rd_val = mtimecmp_q[h][63:32];
        end
      end
      default: rd_val = '0;
    endcase
  end

  // Response captured at accept; writes and errors return zero data.
  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (accept) begin
      err_d   = dec.err;
      rdata_d = (dec.err || we_in) ? 32'h0 : rd_val;
    end
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q    <= StIdle;
      presc_q    <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= '{default: '1};
      msip_q     <= '0;
      mtip_q     <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      mtip_q     <= mtip_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  assign ack_out   = (state_q == StResp);
  assign rdata_out = rdata_q;
  assign err_out   = err_q;
  assign msip_out  = msip_q;
  assign mtip_out  = mtip_q;
  assign mtime_out = mtime_q;

endmodule

// File: tb/tb_clint_mmio.sv
// Self-checking bench for clint_mmio: a 2-hart TICK_DIV=1 instance on the bus
// and an idle 1-hart TICK_DIV=4 instance for the prescaler.
module tb_clint_mmio;

  localparam logic [31:0] MSIP  = 32'h0200_0000;
  localparam logic [31:0] MTIME = 32'h0200_1000;
  localparam logic [31:0] CMP   = 32'h0200_2000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  be = '0;
  logic        ack_out;
  logic [31:0] rdata_out;
  logic        err_out;
  logic [1:0]  msip_out;
  logic [1:0]  mtip_out;
  logic [63:0] mtime_out;

  logic        b_ack, b_err;
  logic [31:0] b_rdata;
  logic [0:0]  b_msip, b_mtip;
  logic [63:0] b_mtime;

  int n_tests = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic        err;
    logic [31:0] rdata;
  } resp_t;
  resp_t exp_q[$];
  resp_t e;

  clint_mmio #(.NUM_HARTS(2), .TICK_DIV(1)) dut (
    .clk_in    (clk),
    .reset_in  (rst_n),
    .req_in    (req),
    .we_in     (we),
    .addr_in   (addr),
    .wdata_in  (wdata),
    .be_in     (be),
    .ack_out   (ack_out),
    .rdata_out (rdata_out),
    .err_out   (err_out),
    .msip_out  (msip_out),
    .mtip_out  (mtip_out),
    .mtime_out (mtime_out)
  );

  clint_mmio #(.NUM_HARTS(1), .TICK_DIV(4)) dut_div4 (
    .clk_in    (clk),
    .reset_in  (rst_n),
    .req_in    (1'b0),
    .we_in     (1'b0),
    .addr_in   (32'h0),
    .wdata_in  (32'h0),
    .be_in     (4'h0),
    .ack_out   (b_ack),
    .rdata_out (b_rdata),
    .err_out   (b_err),
    .msip_out  (b_msip),
    .mtip_out  (b_mtip),
    .mtime_out (b_mtime)
  );

  // Scoreboard: every ack pops the oldest expected response.
  always @(posedge clk) begin
    #1;
    if (ack_out) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_ack: ack_out=1 but no access outstanding");
      end else begin
        e = exp_q.pop_front();
        if (err_out !== e.err || rdata_out !== e.rdata) begin
          n_fail++;
          $display("FAIL resp@%h: got err=%b rdata=%h, required err=%b rdata=%h",
                   e.addr, err_out, rdata_out, e.err, e.rdata);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic reset_dut();
    req = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Called just after a clock edge; returns at the sample point where ack is seen.
  task automatic bus(input logic i_we, input logic [31:0] i_addr, input logic [31:0] i_wdata,
                     input logic [3:0] i_be, input logic [31:0] exp_rd, input logic exp_err,
                     output int cyc);
    cyc = 0;
    if (ack_out) begin
      @(posedge clk);
      #1;
    end
    exp_q.push_back('{addr: i_addr, err: exp_err, rdata: exp_rd});
    req = 1'b1; we = i_we; addr = i_addr; wdata = i_wdata; be = i_be;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!ack_out && cyc < 6);
    req = 1'b0; we = 1'b0; be = '0;
    if (!ack_out) begin
      n_tests++;
      n_fail++;
      $display("FAIL ack_timeout@%h: no ack after %0d cycles, required ack", i_addr, cyc);
      void'(exp_q.pop_back());
    end
  endtask

  task automatic test_reset();
    reset_dut();
    n_tests++;
    if (mtime_out !== 64'd0 || msip_out !== 2'b00 || mtip_out !== 2'b00 || ack_out !== 1'b0 ||
        rdata_out !== 32'h0 || err_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: mtime=%h msip=%b mtip=%b ack=%b rdata=%h err=%b, required all 0",
               mtime_out, msip_out, mtip_out, ack_out, rdata_out, err_out);
    end
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    n_tests++;
    if (mtime_out !== 64'd10 || mtip_out !== 2'b00 || msip_out !== 2'b00) begin
      n_fail++;
      $display("FAIL idle10: mtime=%0d mtip=%b msip=%b, required 10 00 00",
               mtime_out, mtip_out, msip_out);
    end
    n_tests++;
    if (b_mtime !== 64'd2) begin
      n_fail++;
      $display("FAIL idle10_div4: mtime=%0d, required 2", b_mtime);
    end
  endtask

  task automatic test_msip();
    int cyc;
    bus(1'b1, MSIP + 32'd4, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b0, cyc);
    n_tests++;
    if (cyc != 1) begin
      n_fail++;
      $display("FAIL msip_ack_latency: %0d cycles, required 1", cyc);
    end
    n_tests++;
    if (msip_out !== 2'b10) begin
      n_fail++;
      $display("FAIL msip_set: msip=%b, required 10", msip_out);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (ack_out !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_one_cycle: ack=%b, required 0", ack_out);
    end
    bus(1'b0, MSIP + 32'd4, 32'h0, 4'h0, 32'h0000_0001, 1'b0, cyc);
    bus(1'b0, MSIP, 32'h0, 4'h0, 32'h0, 1'b0, cyc);
    // bit0 not enabled, then empty byte enables: neither changes msip
    bus(1'b1, MSIP + 32'd4, 32'h0, 4'b1110, 32'h0, 1'b0, cyc);
    bus(1'b1, MSIP, 32'h1, 4'b0000, 32'h0, 1'b0, cyc);
    n_tests++;
    if (msip_out !== 2'b10) begin
      n_fail++;
      $display("FAIL msip_be_masked: msip=%b, required 10", msip_out);
    end
  endtask

  task automatic test_timer();
    int cyc;
    bus(1'b1, MTIME, 32'h0, 4'hF, 32'h0, 1'b0, cyc);
    bus(1'b1, CMP, 32'd20, 4'hF, 32'h0, 1'b0, cyc);
    bus(1'b1, CMP + 32'd4, 32'h0, 4'hF, 32'h0, 1'b0, cyc);
    bus(1'b0, CMP, 32'h0, 4'h0, 32'd20, 1'b0, cyc);
    for (int i = 0; i < 40 && mtime_out != 64'd20; i++) begin
      @(posedge clk);
      #1;
    end
    n_tests++;
    if (mtime_out !== 64'd20 || mtip_out !== 2'b00) begin
      n_fail++;
      $display("FAIL mtip_before: mtime=%0d mtip=%b, required 20 00", mtime_out, mtip_out);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (mtip_out !== 2'b01) begin
      n_fail++;
      $display("FAIL mtip_rise: mtip=%b, required 01", mtip_out);
    end
    bus(1'b1, CMP + 32'd4, 32'h1, 4'hF, 32'h0, 1'b0, cyc);
    n_tests++;
    if (mtip_out !== 2'b01) begin
      n_fail++;
      $display("FAIL mtip_hold: mtip=%b, required 01", mtip_out);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (mtip_out !== 2'b00) begin
      n_fail++;
      $display("FAIL mtip_fall: mtip=%b, required 00", mtip_out);
    end
  endtask

  task automatic test_wrap();
    int cyc;
    bus(1'b1, MTIME + 32'd4, 32'h0, 4'hF, 32'h0, 1'b0, cyc);
    bus(1'b1, MTIME, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b0, cyc);
    n_tests++;
    if (mtime_out !== 64'h0000_0000_FFFF_FFFF) begin
      n_fail++;
      $display("FAIL mtime_lo_write: mtime=%h, required 00000000ffffffff", mtime_out);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (mtime_out !== 64'h0000_0001_0000_0000) begin
      n_fail++;
      $display("FAIL mtime_carry: mtime=%h, required 0000000100000000", mtime_out);
    end
    bus(1'b1, MTIME, 32'd5, 4'hF, 32'h0, 1'b0, cyc);
    n_tests++;
    if (mtime_out !== 64'h0000_0001_0000_0005) begin
      n_fail++;
      $display("FAIL mtime_write_tick: mtime=%h, required 0000000100000005", mtime_out);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (mtime_out !== 64'h0000_0001_0000_0006) begin
      n_fail++;
      $display("FAIL mtime_resume: mtime=%h, required 0000000100000006", mtime_out);
    end
    bus(1'b0, MTIME + 32'd4, 32'h0, 4'h0, 32'h1, 1'b0, cyc);
  endtask

  task automatic test_errors();
    int cyc;
    bus(1'b1, MSIP + 32'd2, 32'h1, 4'hF, 32'h0, 1'b1, cyc);
    bus(1'b1, MSIP + 32'd8, 32'h1, 4'hF, 32'h0, 1'b1, cyc);
    bus(1'b0, MTIME + 32'd8, 32'h0, 4'h0, 32'h0, 1'b1, cyc);
    bus(1'b0, CMP + 32'd16, 32'h0, 4'h0, 32'h0, 1'b1, cyc);
    bus(1'b1, CMP + 32'd10, 32'h0, 4'hF, 32'h0, 1'b1, cyc);
    bus(1'b0, CMP + 32'd8, 32'h0, 4'h0, 32'hFFFF_FFFF, 1'b0, cyc);
    n_tests++;
    if (msip_out !== 2'b10) begin
      n_fail++;
      $display("FAIL err_no_effect: msip=%b, required 10", msip_out);
    end
  endtask

  task automatic test_byte_enable();
    int cyc;
    bus(1'b1, CMP + 32'd8, 32'h1234_5678, 4'b0101, 32'h0, 1'b0, cyc);
    bus(1'b0, CMP + 32'd8, 32'h0, 4'h0, 32'hFF34_FF78, 1'b0, cyc);
    bus(1'b0, CMP + 32'd12, 32'h0, 4'h0, 32'hFFFF_FFFF, 1'b0, cyc);
  endtask

  task automatic test_prescaler();
    reset_dut();
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk);
      #1;
      n_tests++;
      if (b_mtime !== 64'(n / 4) || mtime_out !== 64'(n)) begin
        n_fail++;
        $display("FAIL prescale_cycle%0d: div4=%0d div1=%0d, required %0d %0d",
                 n, b_mtime, mtime_out, n / 4, n);
      end
    end
  endtask

  task automatic test_reset_mid_resp();
    int cyc;
    bus(1'b1, MSIP + 32'd4, 32'h1, 4'hF, 32'h0, 1'b0, cyc);
    @(posedge clk);
    #1;
    exp_q.push_back('{addr: CMP, err: 1'b0, rdata: 32'h0});
    req = 1'b1; we = 1'b1; addr = CMP; wdata = 32'd7; be = 4'hF;
    @(posedge clk);
    #1;
    req = 1'b0; we = 1'b0; be = '0;
    n_tests++;
    if (ack_out !== 1'b1) begin
      n_fail++;
      $display("FAIL resp_before_reset: ack=%b, required 1", ack_out);
    end
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if (ack_out !== 1'b0 || msip_out !== 2'b00 || mtime_out !== 64'd0 || mtip_out !== 2'b00) begin
      n_fail++;
      $display("FAIL async_reset: ack=%b msip=%b mtime=%h mtip=%b, required all 0",
               ack_out, msip_out, mtime_out, mtip_out);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus(1'b0, MTIME, 32'h0, 4'h0, 32'h0, 1'b0, cyc);
    bus(1'b0, CMP, 32'h0, 4'h0, 32'hFFFF_FFFF, 1'b0, cyc);
    bus(1'b0, CMP + 32'd4, 32'h0, 4'h0, 32'hFFFF_FFFF, 1'b0, cyc);
    bus(1'b0, MSIP + 32'd4, 32'h0, 4'h0, 32'h0, 1'b0, cyc);
    bus(1'b0, CMP + 32'd12, 32'h0, 4'h0, 32'hFFFF_FFFF, 1'b0, cyc);
  endtask

  initial begin
    test_reset();
    test_msip();
    test_timer();
    test_wrap();
    test_errors();
    test_byte_enable();
    test_prescaler();
    test_reset_mid_resp();
    repeat (3) @(posedge clk);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clint_mmio.md
Name: clint_mmio

Overview:
- Multi-hart core-local interruptor for the Internal I/O space.
- Implements the MSIP, MTIME and MTIMECMP memory-mapped registers at the base addresses defined in the CPU parameter package.
- Generalised to NUM_HARTS harts, with a programmable timebase prescaler.
- Sits behind mem_io's internal I/O decode; drives per-hart machine software and timer interrupt lines, plus a 64-bit time value for the time/timeh CSR shadow.

Parameters:
- NUM_HARTS, 1, number of harts (1..32); one MSIP and one MTIMECMP per hart.
- MSIP_BASE, 32'h0200_0000, byte address of hart 0 MSIP word; hart h at MSIP_BASE+4*h.
- MTIME_BASE, 32'h0200_1000, byte address of mtime low word; high word at +4.
- MTIMECMP_BASE, 32'h0200_2000, hart h mtimecmp low word at MTIMECMP_BASE+8*h; high word at +4.
- TICK_DIV, 1, mtime increments once every TICK_DIV clk_in cycles (1..65535).

Ports:
- clk_in  input  1  system clock.
- reset_in  input  1  asynchronous, active-low reset.
- req_in  input  1  bus request; held stable until ack_out.
- we_in  input  1  1 = write, 0 = read.
- addr_in  input  32  byte address, already within the internal I/O range.
- wdata_in  input  32  write data.
- be_in  input  4  byte enables for writes.
- ack_out  output  1  one-cycle response strobe.
- rdata_out  output  32  read data, valid with ack_out.
- err_out  output  1  access error, valid with ack_out.
- msip_out  output  NUM_HARTS  machine software interrupt pending, per hart.
- mtip_out  output  NUM_HARTS  machine timer interrupt pending, per hart.
- mtime_out  output  64  current mtime.

Behaviour:
- Reset (async assert, sync release) values:
  - mtime = 0, prescaler = 0, all mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, all msip = 0.
  - mtip_out = 0, ack_out = 0, err_out = 0, rdata_out = 0.
  - FSM returns to IDLE; any in-flight request is dropped with no ack.
- FSM, two states:
  - IDLE: if req_in, perform the access at this edge and go to RESP.
  - RESP: ack_out=1 for exactly one cycle, then go to IDLE. A request still asserted in that cycle is not re-accepted; the requester must drop req_in on ack.
  - Throughput: one access per 2 cycles.
- Read data:
  - Registered at accept and presented in RESP.
  - MSIP word returns {31'b0, msip[h]}.
  - 64-bit registers are read as two 32-bit halves. No atomic snapshot; software handles hi/lo/hi retry.
- Writes:
  - Byte enables are honoured per byte.
  - MSIP: only bit0 is writable; other bits read 0.
  - A write with be_in=0 is accepted, has no effect, and returns no error.
- Errors:
  - addr_in[1:0] != 0, or an address matching no register (including hart index >= NUM_HARTS) sets err_out=1 with ack.
  - An erroring access has no register side effect; rdata_out = 0.
- Prescaler and mtime:
  - Prescaler counts 0..TICK_DIV-1; tick asserts when it equals TICK_DIV-1, then wraps to 0.
  - mtime += 1 on tick, full 64-bit wrap (FFFF_FFFF_FFFF_FFFF -> 0).
  - Carry from low to high word is in the same cycle.
  - TICK_DIV=1 means a tick every cycle.
- Write to mtime coinciding with a tick: the write wins for both halves that cycle. The written half takes wdata, the unwritten half holds its value, and no increment occurs. The prescaler is unaffected.
- mtip_out[h]:
  - Registered (mtime >= mtimecmp[h]), unsigned 64-bit compare.
  - Reflects register state one cycle after any change.
  - Level signal; stays high until mtimecmp is raised or mtime wraps below it.
- msip_out[h] is driven directly from the msip register.
- mtime_out is driven directly from the mtime register.

Decomposition:
- cpu_params_pkg holds:
  - the base-address constants;
  - a new CLINT_TICK_DIV parameter;
  - a new NUM_HARTS parameter.
- New typedef in cpu_structs_pkg: clint_sel_t enum {SEL_NONE, SEL_MSIP, SEL_MTIME_LO, SEL_MTIME_HI, SEL_CMP_LO, SEL_CMP_HI}, plus the hart index.
- One sub-module: clint_addr_dec, combinational decode of addr_in to clint_sel_t, hart index and error.

Test Plan:
- Reset then idle 10 cycles, TICK_DIV=1 -> mtime_out=10, mtip_out=0, msip_out=0.
- Write MSIP_BASE+4 = 32'hFFFF_FFFF, NUM_HARTS=2 -> msip_out=2'b10, readback 32'h0000_0001, ack_out one cycle after accept.
- Write mtimecmp[0] lo=20, hi=0 with mtime<20 -> mtip_out[0] rises the cycle after mtime reaches 20; then write hi=1 -> mtip_out[0] falls next cycle.
- mtime=32'hFFFF_FFFF low / 0 high, tick -> mtime_out=64'h1_0000_0000. Write mtime lo=5 on a tick cycle -> lo=5, hi unchanged, no increment.
- TICK_DIV=4 -> mtime increments every 4th cycle. Write addr MSIP_BASE+2 -> err_out=1, no state change. Write MSIP_BASE+4*NUM_HARTS -> err_out=1.
- Assert reset_in low mid-RESP -> ack_out drops immediately; all registers read back their reset values.
